// File: rtl/stream_upsizer.sv
// Packs a ready/valid stream of DATA_W-bit beats into RATIO-lane words.
// A beat marked last closes the word early; m_keep_o marks the filled lanes.
module stream_upsizer #(
    parameter int DATA_W = 64,
    parameter int RATIO  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_W-1:0]         s_data_i,
    input  logic                      s_last_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [DATA_W*RATIO-1:0]   m_data_o,
    output logic [RATIO-1:0]          m_keep_o,
    output logic                      m_last_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i
);

    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    generate
        if (RATIO < 2) begin : g_bad_ratio
            $error("stream_upsizer: RATIO must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lane;
    logic             pop;
    logic             acc;
    logic             closes;

    assign s_ready_o = !rst_i && (!m_valid_o || m_ready_i);
    assign pop       = m_valid_o && m_ready_i;
    assign acc       = s_valid_i && s_ready_o;

    // A presented word always has cnt at 0, so a pop-and-accept restarts at lane 0.
    assign lane   = m_valid_o ? '0 : cnt;
    assign closes = (lane == LAST_LANE) || s_last_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= '0;
            m_data_o  <= '0;
            m_keep_o  <= '0;
            m_last_o  <= 1'b0;
            m_valid_o <= 1'b0;
        end else if (acc) begin
            for (int k = 0; k < RATIO; k++) begin
                if (lane == CNT_W'(k)) begin
                    m_data_o[k*DATA_W +: DATA_W] <= s_data_i;
                    m_keep_o[k]                  <= 1'b1;
                end else if (pop) begin
                    m_data_o[k*DATA_W +: DATA_W] <= '0;
                    m_keep_o[k]                  <= 1'b0;
                end
            end
            if (closes) begin
                m_valid_o <= 1'b1;
                m_last_o  <= s_last_i;
                cnt       <= '0;
            end else begin
                m_valid_o <= 1'b0;
                m_last_o  <= 1'b0;
                cnt       <= lane + CNT_W'(1);
            end
        end else if (pop) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_keep_o  <= '0;
            m_last_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Scoreboard bench for stream_upsizer: a queue-based packing model predicts
// every output word and s_ready_o; a separate monitor compares presented words.
module tb_stream_upsizer;

    localparam int DATA_W = 8;
    localparam int RATIO  = 4;
    localparam int WORD_W = DATA_W * RATIO;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [DATA_W-1:0] s_data_i;
    logic              s_last_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [WORD_W-1:0] m_data_o;
    logic [RATIO-1:0]  m_keep_o;
    logic              m_last_o;
    logic              m_valid_o;
    logic              m_ready_i;

    stream_upsizer #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_keep_o  (m_keep_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [RATIO-1:0]  keep;
        logic              last;
    } word_t;

    word_t             exp_q[$];
    logic [DATA_W-1:0] partial[$];
    int                vectors     = 0;
    int                miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Word formed from the beats collected so far: beat k lands in lane k.
    function automatic word_t build_word(input logic last);
        word_t w;
        w = '0;
        for (int k = 0; k < partial.size(); k++)
            w.data = w.data | (WORD_W'(partial[k]) << (k * DATA_W));
        w.keep = RATIO'((1 << partial.size()) - 1);
        w.last = last;
        return w;
    endfunction

    // One clock cycle: drive at the falling edge, predict ready, update the model.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic l,
                        input logic mr, input logic r);
        logic exp_ready;
        @(negedge clk_i);
        s_valid_i = v;
        s_data_i  = d;
        s_last_i  = l;
        m_ready_i = mr;
        rst_i     = r;
        #1;
        exp_ready = !r && (exp_q.size() == 0 || mr);
        check("s_ready", 32'(s_ready_o), 32'(exp_ready));
        if (r) begin
            exp_q.delete();
            partial.delete();
        end else if (v && exp_ready) begin
            partial.push_back(d);
            if (partial.size() == RATIO || l) begin
                exp_q.push_back(build_word(l));
                partial.delete();
            end
        end
    endtask

    task automatic check_word(input string name, input logic v, input logic [WORD_W-1:0] d,
                              input logic [RATIO-1:0] k, input logic l);
        check({name, "_valid"}, 32'(m_valid_o), 32'(v));
        check({name, "_data"},  32'(m_data_o),  32'(d));
        check({name, "_keep"},  32'(m_keep_o),  32'(k));
        check({name, "_last"},  32'(m_last_o),  32'(l));
    endtask

    // Monitor: every presented word must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            #3;
            if (!rst_i && m_valid_o) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_word: got data 0x%0h keep 0x%0h, expected no word",
                             m_data_o, m_keep_o);
                end else begin
                    check("sb_data", 32'(m_data_o), 32'(exp_q[0].data));
                    check("sb_keep", 32'(m_keep_o), 32'(exp_q[0].keep));
                    check("sb_last", 32'(m_last_o), 32'(exp_q[0].last));
                    if (m_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b1;
        rst_i     = 1'b1;

        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_word("reset", 1'b0, '0, '0, 1'b0);

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
            if (i == 5) check_word("full0", 1'b1, 32'h04030201, 4'hF, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_word("full1", 1'b1, 32'h08070605, 4'hF, 1'b0);

        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hBB, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_word("early", 1'b1, 32'h0000BBAA, 4'h3, 1'b1);

        step(1'b1, 8'h5C, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_word("single", 1'b1, 32'h0000005C, 4'h1, 1'b1);

        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
            check("bp_ready", 32'(s_ready_o), 32'h0);
            check_word("bp_hold", 1'b1, 32'hC3C2C1C0, 4'hF, 1'b0);
        end
        step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_word("bp_resume", 1'b0, 32'h00000099, 4'h1, 1'b0);
        step(1'b1, 8'h9A, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_word("bp_tail", 1'b1, 32'h00009A99, 4'h3, 1'b1);

        step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
        check("rst_ready", 32'(s_ready_o), 32'h0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_word("rst_mid", 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_word("fresh", 1'b1, 32'hE3E2E1E0, 4'hF, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1999) == 0);
        end

        step(1'b1, 8'($urandom), 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
